// File: rtl/mio_bus_pkg.sv
// Shared constants and FSM encoding for the CPU memory/IO bus controller.
package mio_bus_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_SLV   = 16;
    localparam int unsigned IDX_W     = $clog2(MAX_SLV);
    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side and slave-side signals of the memory/IO bus controller.
interface mio_bus_ctrl_if #(
    parameter int unsigned NUM_SLV = 6,
    parameter int unsigned ADDR_W  = 15
) ();
    import mio_bus_pkg::*;

    logic                      cpu_req;
    logic                      cpu_we;
    logic [DATA_W-1:0]         cpu_addr;
    logic [DATA_W-1:0]         cpu_wdata;
    logic [3:0]                cpu_be;
    logic [DATA_W-1:0]         cpu_rdata;
    logic                      cpu_ready;
    logic                      cpu_err;
    logic [NUM_SLV-1:0]        slv_sel;
    logic                      slv_we;
    logic [ADDR_W-1:0]         slv_addr;
    logic [DATA_W-1:0]         slv_wdata;
    logic [3:0]                slv_be;
    logic [NUM_SLV*DATA_W-1:0] slv_rdata;

    // CPU plus peripherals: drives requests and slave read data
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, slv_rdata,
        input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata, slv_be
    );

    // Bus controller view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, slv_rdata,
        output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata, slv_be
    );

endinterface

// File: rtl/mio_addr_decode.sv
// Base/mask window compare with lowest-index priority; purely combinational.
module mio_addr_decode
    import mio_bus_pkg::*;
#(
    parameter int unsigned                NUM_SLV  = 6,
    parameter logic [NUM_SLV*DATA_W-1:0] SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*DATA_W-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}}
) (
    input  logic [DATA_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the top so the lowest matching window is written last
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[DATA_W*i +: DATA_W]) == SLV_BASE[DATA_W*i +: DATA_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered CPU memory/IO bus controller: window decode, per-slave wait states, ready/err.
// Optional MIO_BUS_ERR_LOG_EN adds err_addr/err_cnt logging of unmapped accesses.
module mio_bus_ctrl
    import mio_bus_pkg::*;
#(
    parameter int unsigned                NUM_SLV  = 6,
    parameter int unsigned                ADDR_W   = 15,
    parameter logic [NUM_SLV*DATA_W-1:0] SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*DATA_W-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}},
    parameter logic [NUM_SLV*WAIT_W-1:0] WAIT_CYC = {NUM_SLV{4'd0}}
) (
    input  logic           clk,
    input  logic           rst,
    mio_bus_ctrl_if.slave  bus
`ifdef MIO_BUS_ERR_LOG_EN
    ,
    output logic [DATA_W-1:0]    err_addr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    state_e            state;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] sel_wait;
    logic [DATA_W-1:0] sel_rdata;
    logic [DATA_W-1:0] resp_data;

    mio_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (bus.cpu_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Per-slave wait count and read data of the latched window
    always_comb begin
        sel_wait  = '0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_wait  = WAIT_CYC[WAIT_W*i +: WAIT_W];
                sel_rdata = bus.slv_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign resp_data = we_q ? '0 : sel_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx_q         <= '0;
            we_q          <= 1'b0;
            cnt           <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.slv_sel   <= '0;
            bus.slv_we    <= 1'b0;
            bus.slv_addr  <= '0;
            bus.slv_wdata <= '0;
            bus.slv_be    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        idx_q         <= dec_idx;
                        we_q          <= bus.cpu_we;
                        bus.slv_addr  <= bus.cpu_addr[ADDR_W+1:2];
                        bus.slv_wdata <= bus.cpu_wdata;
                        bus.slv_be    <= bus.cpu_be;
                        if (dec_hit) begin
                            state       <= ST_STROBE;
                            bus.slv_sel <= NUM_SLV'(1) << dec_idx;
                            bus.slv_we  <= bus.cpu_we;
                        end else begin
                            state         <= ST_RESP;
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_err   <= 1'b1;
                            bus.cpu_rdata <= '0;
                        end
                    end
                end
                ST_STROBE: begin
                    bus.slv_sel <= '0;
                    bus.slv_we  <= 1'b0;
                    cnt         <= sel_wait;
                    if (sel_wait == '0) begin
                        state         <= ST_RESP;
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_rdata <= resp_data;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - WAIT_W'(1);
                    if (cnt == WAIT_W'(1)) begin
                        state         <= ST_RESP;
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_rdata <= resp_data;
                    end
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    bus.cpu_ready <= 1'b0;
                    bus.cpu_err   <= 1'b0;
                    bus.cpu_rdata <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MIO_BUS_ERR_LOG_EN
    // Unmapped-access log, updated as the access enters RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (state == ST_IDLE && bus.cpu_req && !dec_hit) begin
            err_addr <= bus.cpu_addr;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl; scoreboard of expected responses per access.
module tb_mio_bus_ctrl;

    localparam int unsigned NUM_SLV = 6;
    localparam int unsigned ADDR_W  = 15;
    localparam logic [NUM_SLV*32-1:0] BASE = {32'hF000_0004, 32'hF000_0000, 32'hE000_0000,
                                              32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NUM_SLV*32-1:0] MASK = {32'hF000_0004, 32'hF000_0004, 32'hF000_0000,
                                              32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    localparam logic [NUM_SLV*4-1:0]  WAITS = {4'd2, 4'd0, 4'd3, 4'd1, 4'd5, 4'd0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mio_bus_ctrl_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W)) bus ();

`ifdef MIO_BUS_ERR_LOG_EN
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;
`endif

    mio_bus_ctrl #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .WAIT_CYC (WAITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MIO_BUS_ERR_LOG_EN
        ,
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
`endif
    );

    typedef struct {
        int                 lat;
        int                 n_sel;
        int                 n_we;
        logic [NUM_SLV-1:0] sel;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [31:0]        wdata;
        logic [3:0]         be;
        logic [31:0]        rdata;
        logic               err;
        logic [31:0]        post_rdata;
        logic               post_err;
        logic               post_ready;
    } obs_t;

    typedef struct {
        int                 lat;
        logic [NUM_SLV-1:0] sel;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [31:0]        wdata;
        logic [3:0]         be;
        logic [31:0]        rdata;
        logic               err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd [NUM_SLV];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdata();
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            rd[i] = $urandom;
            bus.slv_rdata[32*i +: 32] = rd[i];
        end
    endtask

    // Reference model: first matching window in ascending order
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   hit_i = -1;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (hit_i < 0 && ((addr & MASK[32*i +: 32]) == BASE[32*i +: 32])) hit_i = i;
        end
        e.we    = we;
        e.addr  = addr[ADDR_W+1:2];
        e.wdata = wdata;
        e.be    = be;
        if (hit_i < 0) begin
            e.lat   = 1;
            e.sel   = '0;
            e.rdata = '0;
            e.err   = 1'b1;
        end else begin
            e.lat   = 2 + int'(WAITS[4*hit_i +: 4]);
            e.sel   = NUM_SLV'(1) << hit_i;
            e.rdata = we ? 32'h0 : rd[hit_i];
            e.err   = 1'b0;
        end
        return e;
    endfunction

    // Drive one request for a single cycle, then record what the bus does until one cycle after ready
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output obs_t o);
        o = '{default: 0};
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_be    = be;
        tick();
        bus.cpu_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.slv_sel != '0) begin
                o.n_sel++;
                o.sel   = bus.slv_sel;
                o.we    = bus.slv_we;
                o.addr  = bus.slv_addr;
                o.wdata = bus.slv_wdata;
                o.be    = bus.slv_be;
            end
            if (bus.slv_we) o.n_we++;
            if (bus.cpu_ready) begin
                o.lat   = c;
                o.rdata = bus.cpu_rdata;
                o.err   = bus.cpu_err;
                tick();
                o.post_rdata = bus.cpu_rdata;
                o.post_err   = bus.cpu_err;
                o.post_ready = bus.cpu_ready;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int n_ready;
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({bus.cpu_rdata, bus.cpu_ready, bus.cpu_err, bus.slv_sel, bus.slv_we,
             bus.slv_addr, bus.slv_wdata, bus.slv_be} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs sel=%b ready=%b", bus.slv_sel, bus.cpu_ready);
        else n_pass++;
`ifdef MIO_BUS_ERR_LOG_EN
        n_total++;
        if ({err_addr, err_cnt} !== 40'h0)
            $display("FAIL reset_errlog: got addr=%h cnt=%0d, expected 0", err_addr, err_cnt);
        else n_pass++;
`endif
        rst = 1'b0;
        tick();
        // Slow window 1 (5 wait states), aborted by reset while waiting
        set_rdata();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h1000_0ABC;
        bus.cpu_wdata = 32'h1234_5678;
        bus.cpu_be    = 4'hA;
        tick();
        bus.cpu_req = 1'b0;
        n_total++;
        if (bus.slv_sel !== 6'b000010 || bus.slv_addr !== 15'h2AF)
            $display("FAIL reset_pre_strobe: got sel=%b addr=%h, expected 000010/2af", bus.slv_sel, bus.slv_addr);
        else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.cpu_rdata, bus.cpu_ready, bus.cpu_err, bus.slv_sel, bus.slv_we,
             bus.slv_addr, bus.slv_wdata, bus.slv_be} !== '0)
            $display("FAIL reset_mid_wait: got addr=%h wdata=%h be=%h, expected 0", bus.slv_addr, bus.slv_wdata, bus.slv_be);
        else n_pass++;
        rst = 1'b0;
        n_ready = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.cpu_ready) n_ready++;
        end
        n_total++;
        if (n_ready !== 0) $display("FAIL reset_no_ready: got %0d ready pulses, expected 0", n_ready);
        else n_pass++;
    endtask

    task automatic test_ram_read();
        obs_t o;
        exp_t e;
        set_rdata();
        exp_q.push_back(model(1'b0, 32'h0000_0010, 32'h0, 4'hF));
        run_access(1'b0, 32'h0000_0010, 32'h0, 4'hF, o);
        e = exp_q.pop_front();
        n_total++;
        if (o.sel !== 6'b000001 || o.addr !== 15'd4 || o.n_sel !== 1)
            $display("FAIL ram_strobe: got sel=%b addr=%0d n=%0d, expected 000001/4/1", o.sel, o.addr, o.n_sel);
        else n_pass++;
        n_total++;
        if (o.lat !== 2 || o.lat !== e.lat) $display("FAIL ram_latency: got %0d, expected 2", o.lat);
        else n_pass++;
        n_total++;
        if (o.rdata !== e.rdata || o.err !== 1'b0)
            $display("FAIL ram_rdata: got %h err=%b, expected %h err=0", o.rdata, o.err, e.rdata);
        else n_pass++;
        n_total++;
        if ({o.post_rdata, o.post_err, o.post_ready} !== '0)
            $display("FAIL ram_post_resp: got rdata=%h err=%b ready=%b, expected 0", o.post_rdata, o.post_err, o.post_ready);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        obs_t o;
        exp_t e;
        set_rdata();
        exp_q.push_back(model(1'b0, 32'hE000_0000, 32'h0, 4'hF));
        run_access(1'b0, 32'hE000_0000, 32'h0, 4'hF, o);
        e = exp_q.pop_front();
        n_total++;
        if (o.lat !== 5 || o.lat !== e.lat) $display("FAIL wait_latency: got %0d, expected 5", o.lat);
        else n_pass++;
        n_total++;
        if (o.sel !== 6'b001000 || o.n_sel !== 1)
            $display("FAIL wait_strobe: got sel=%b n=%0d, expected 001000/1", o.sel, o.n_sel);
        else n_pass++;
        n_total++;
        if (o.rdata !== e.rdata) $display("FAIL wait_rdata: got %h, expected %h", o.rdata, e.rdata);
        else n_pass++;
    endtask

    task automatic test_overlap();
        obs_t o;
        exp_t e;
        set_rdata();
        exp_q.push_back(model(1'b0, 32'hF000_0004, 32'h0, 4'hF));
        run_access(1'b0, 32'hF000_0004, 32'h0, 4'hF, o);
        e = exp_q.pop_front();
        n_total++;
        if (o.sel !== 6'b100000 || o.lat !== e.lat || o.rdata !== e.rdata)
            $display("FAIL overlap_win5: got sel=%b lat=%0d rdata=%h, expected 100000/%0d/%h", o.sel, o.lat, o.rdata, e.lat, e.rdata);
        else n_pass++;
        exp_q.push_back(model(1'b0, 32'hF000_0000, 32'h0, 4'hF));
        run_access(1'b0, 32'hF000_0000, 32'h0, 4'hF, o);
        e = exp_q.pop_front();
        n_total++;
        if (o.sel !== 6'b010000 || o.lat !== e.lat || o.rdata !== e.rdata)
            $display("FAIL overlap_win4: got sel=%b lat=%0d rdata=%h, expected 010000/%0d/%h", o.sel, o.lat, o.rdata, e.lat, e.rdata);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        obs_t o;
        exp_t e;
        int   n_ok;
        logic [31:0] a;
        exp_q.push_back(model(1'b1, 32'h5000_0000, 32'hDEAD_BEEF, 4'hF));
        run_access(1'b1, 32'h5000_0000, 32'hDEAD_BEEF, 4'hF, o);
        e = exp_q.pop_front();
        n_total++;
        if (o.lat !== 1 || o.err !== e.err || o.rdata !== 32'h0)
            $display("FAIL unmapped_resp: got lat=%0d err=%b rdata=%h, expected 1/1/0", o.lat, o.err, o.rdata);
        else n_pass++;
        n_total++;
        if (o.n_sel !== 0 || o.n_we !== 0)
            $display("FAIL unmapped_no_strobe: got sel cycles=%0d we cycles=%0d, expected 0/0", o.n_sel, o.n_we);
        else n_pass++;
        n_total++;
        if (o.post_err !== 1'b0 || o.post_ready !== 1'b0)
            $display("FAIL unmapped_post: got err=%b ready=%b, expected 0/0", o.post_err, o.post_ready);
        else n_pass++;
`ifdef MIO_BUS_ERR_LOG_EN
        n_total++;
        if (err_addr !== 32'h5000_0000 || err_cnt !== 8'd1)
            $display("FAIL errlog_first: got addr=%h cnt=%0d, expected 50000000/1", err_addr, err_cnt);
        else n_pass++;
`endif
        n_ok = 0;
        a    = 32'h0;
        for (int k = 1; k < 300; k++) begin
            a = 32'h5000_0000 | (32'(k) << 2);
            exp_q.push_back(model(k[0], a, 32'(k), 4'h3));
            run_access(k[0], a, 32'(k), 4'h3, o);
            e = exp_q.pop_front();
            if (o.lat == e.lat && o.err === e.err && o.n_sel == 0 && o.rdata === 32'h0) n_ok++;
        end
        n_total++;
        if (n_ok !== 299) $display("FAIL unmapped_burst: got %0d good responses, expected 299", n_ok);
        else n_pass++;
`ifdef MIO_BUS_ERR_LOG_EN
        n_total++;
        if (err_cnt !== 8'hFF || err_addr !== a)
            $display("FAIL errlog_saturate: got cnt=%h addr=%h, expected ff/%h", err_cnt, err_addr, a);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        localparam int N = 4;
        logic [31:0] wd [N];
        logic [3:0]  be [N];
        exp_t e;
        int   k = 0;
        int   cyc = 0;
        int   last = -1;
        int   n_ready = 0;
        for (int i = 0; i < N; i++) begin
            wd[i] = $urandom;
            be[i] = 4'($urandom_range(1, 15));
            exp_q.push_back(model(1'b1, 32'h200 + 32'(4*i), wd[i], be[i]));
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h200;
        bus.cpu_wdata = wd[0];
        bus.cpu_be    = be[0];
        while (exp_q.size() > 0 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.cpu_ready) begin
                n_ready++;
                n_total++;
                if ({bus.cpu_err, bus.cpu_rdata} !== 33'h0)
                    $display("FAIL b2b_resp: got err=%b rdata=%h, expected 0/0", bus.cpu_err, bus.cpu_rdata);
                else n_pass++;
            end
            if (bus.slv_sel != '0) begin
                e = exp_q.pop_front();
                n_total++;
                if (bus.slv_sel !== e.sel || bus.slv_we !== 1'b1 || bus.slv_addr !== e.addr ||
                    bus.slv_wdata !== e.wdata || bus.slv_be !== e.be)
                    $display("FAIL b2b_write%0d: got sel=%b we=%b addr=%h wdata=%h be=%h, expected %b/1/%h/%h/%h",
                             k, bus.slv_sel, bus.slv_we, bus.slv_addr, bus.slv_wdata, bus.slv_be,
                             e.sel, e.addr, e.wdata, e.be);
                else n_pass++;
                if (last >= 0) begin
                    n_total++;
                    if (cyc - last !== 3) $display("FAIL b2b_spacing%0d: got %0d cycles, expected 3", k, cyc - last);
                    else n_pass++;
                end
                last = cyc;
                k++;
                if (k < N) begin
                    bus.cpu_addr  = 32'h200 + 32'(4*k);
                    bus.cpu_wdata = wd[k];
                    bus.cpu_be    = be[k];
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end
        end
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL b2b_timeout: got %0d writes missing, expected 0", exp_q.size());
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.cpu_ready) n_ready++;
        end
        n_total++;
        if (n_ready !== N) $display("FAIL b2b_ready_count: got %0d, expected %0d", n_ready, N);
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_be    = '0;
        bus.slv_rdata = '0;
        test_reset();
        test_ram_read();
        test_wait_states();
        test_overlap();
        test_unmapped();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Parametrised, registered successor to the CPU memory/IO bus decoder.
- Decodes a CPU access against NUM_SLV address windows, each with a programmable base and mask, and drives a one-hot select to the matching slave.
- Applies a per-slave fixed wait-state count and returns read data plus a one-cycle ready/error handshake.
- Sits between the CPU data port and RAM, VRAM, GPIO, 7-segment and counter peripherals.

Parameters:
- NUM_SLV, 6, number of slave windows (1..16).
- ADDR_W, 15, width of the word address sent to slaves (cpu_addr[ADDR_W+1:2]).
- SLV_BASE, {NUM_SLV{32'h0}}, packed NUM_SLV x 32-bit window bases; slave i occupies bits [32*i+31:32*i].
- SLV_MASK, {NUM_SLV{32'hF000_0000}}, packed NUM_SLV x 32-bit compare masks.
- WAIT_CYC, {NUM_SLV{4'd0}}, packed NUM_SLV x 4-bit wait states per slave (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  access request, sampled in IDLE only.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_be  in  4  byte enables.
- cpu_rdata  out  32  read data, valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  with cpu_ready: access hit no window.
- slv_sel  out  NUM_SLV  one-hot select, one cycle per access.
- slv_we  out  1  write strobe, qualified by slv_sel.
- slv_addr  out  ADDR_W  word address.
- slv_wdata  out  32  write data.
- slv_be  out  4  byte enables.
- slv_rdata  in  NUM_SLV*32  packed slave read data; slave i at [32*i+31:32*i].

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0. Reset asserted mid-access aborts the access immediately. No ready pulse is issued for an aborted access.
- Decode: hit[i] = ((cpu_addr & SLV_MASK[i]) == SLV_BASE[i]). Lowest index wins when windows overlap. No hit means the access is unmapped.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE, cpu_req = 1:
  - Latch addr, we, wdata, be and the decoded index.
  - Mapped access goes to STROBE.
  - Unmapped access goes to RESP with err.
- STROBE (one cycle):
  - slv_sel[idx] = 1; slv_we = latched we.
  - slv_addr, slv_wdata and slv_be are driven from the latches and held through WAIT.
  - Load counter with WAIT_CYC[idx].
  - Counter 0 goes to RESP; otherwise go to WAIT.
- WAIT:
  - slv_sel = 0; counter decrements each cycle.
  - Counter reaching 1 goes to RESP on the next edge, so WAIT lasts exactly WAIT_CYC[idx] cycles.
- RESP (one cycle):
  - cpu_ready = 1.
  - Read: cpu_rdata = slv_rdata[idx] registered on entry to RESP.
  - Write or unmapped: cpu_rdata = 0.
  - cpu_err = 1 only for unmapped accesses.
  - Next state IDLE.
- Latency from cpu_req sampled to cpu_ready:
  - Mapped: 2 + WAIT_CYC[idx] cycles.
  - Unmapped: 1 cycle.
- cpu_req is ignored outside IDLE. A request held high across RESP is taken as a new access in the IDLE cycle that follows, so back-to-back throughput is one access per 3 + WAIT_CYC cycles.
- Unmapped write: no slv_sel or slv_we is ever asserted.
- cpu_rdata and cpu_err return to 0 the cycle after RESP.

Optional Feature:
- Macro: MIO_BUS_ERR_LOG_EN.
- When defined, two extra output ports are added:
  - err_addr [31:0]: captures the latched address of the most recent unmapped access, in its RESP cycle.
  - err_cnt [7:0]: counts unmapped accesses, saturating at 8'hFF.
  - Both reset to 0.
- When undefined, neither port exists and there is no extra logic.

Decomposition:
- Package mio_bus_pkg holds:
  - the FSM state encoding (2-bit: IDLE=0, STROBE=1, WAIT=2, RESP=3);
  - the CPU data width constant (32);
  - the max-slaves constant (16).
- Sub-module mio_addr_decode: combinational base/mask compare plus priority encode, producing hit and index. All sequential logic stays in the top module.

Test Plan:
- Reset: assert rst mid-WAIT on a slave with WAIT_CYC = 5 -> all outputs 0 immediately; no cpu_ready after release.
- RAM read, window 0 (base 0, mask F000_0000, wait 0), cpu_addr = 32'h0000_0010:
  - slv_sel = 6'b000001 and slv_addr = 4 in cycle 1;
  - cpu_ready with cpu_rdata = slave0 data in cycle 2.
- Wait states, window 3 with WAIT_CYC = 3, read at 32'hE000_0000 -> cpu_ready exactly 5 cycles after the request; slv_sel high for 1 cycle only.
- Overlap priority:
  - window 4 = base F000_0000, mask F000_0004; window 5 = base F000_0004, mask F000_0004;
  - access 32'hF000_0004 -> slv_sel[5];
  - access 32'hF000_0000 -> slv_sel[4].
- Unmapped write to 32'h5000_0000:
  - cpu_ready and cpu_err after 1 cycle; slv_sel and slv_we stay 0;
  - with MIO_BUS_ERR_LOG_EN: err_addr = 32'h5000_0000 and err_cnt = 1;
  - 300 such accesses -> err_cnt = 8'hFF.
- Back-to-back writes with cpu_req held high, wait 0 -> writes land every 3 cycles; slv_wdata and slv_be match each request.
